// File: rtl/synchronous_ram_pkg.sv
// synchronous_ram_pkg
// Shared definitions for the synchronous_ram slice:
//   - default word/address widths
//   - INIT/RUN state type used by the clear sequencer
//   - byte_parity() helper, only referenced when SYNCHRONOUS_RAM_PARITY_EN is defined
package synchronous_ram_pkg;

  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_ADDR_W = 8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Even parity: the returned bit makes the byte plus parity bit have an even
  // number of ones, so an all-zero word carries all-zero parity.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/synchronous_ram_init_seq.sv
// synchronous_ram_init_seq
// Post-reset clear sequencer. It walks every address writing zero, then hands
// the array port over to the user interface.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | clearing: mem[r_clr_addr] <= 0 each cycle, user port ignored
// ST_RUN  | normal operation: user we/addr/data_in drive the array
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_we/i_addr/i_data   user write request
//   o_mem_we/o_mem_addr/o_mem_data   muxed array write port
//   o_run           high in ST_RUN
//   o_init_done     high once the clear has completed
module synchronous_ram_init_seq
  import synchronous_ram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_run,
  output logic              o_init_done
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_clr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_clr_addr <= '0;
    end else if (r_state == ST_INIT) begin
      r_clr_addr <= r_clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      // The edge that writes the last address is the one that enters RUN,
      // so init_done rises together with the final clear write.
      if (r_clr_addr == {ADDR_W{1'b1}}) begin
        r_state <= ST_RUN;
      end
    end
  end

  always_comb begin
    o_run       = (r_state == ST_RUN);
    o_init_done = o_run;
    o_mem_we    = 1'b1;
    o_mem_addr  = r_clr_addr;
    o_mem_data  = '0;
    if (o_run) begin
      o_mem_we   = i_we;
      o_mem_addr = i_addr;
      o_mem_data = i_data;
    end
  end

endmodule

// File: rtl/synchronous_ram.sv
// synchronous_ram
// Single-port 2**ADDR_W x DATA_W RAM with registered, write-first read data and
// a hardware clear after every reset.
//
// Optional feature macro: SYNCHRONOUS_RAM_PARITY_EN
//   When defined, one even-parity bit per byte is stored with each word and
//   parity_err flags a mismatch on read cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      async active-low reset (restarts the clear)
//   we         write enable (ignored until init_done)
//   addr       word address for read and write
//   data_in    write data
//   data_out   registered read data, 0 during reset/clear
//   init_done  high once every word has been cleared
//   parity_err registered parity mismatch flag (macro only)
module synchronous_ram
  import synchronous_ram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
`ifdef SYNCHRONOUS_RAM_PARITY_EN
  output logic              parity_err,
`endif
  output logic              init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic              w_run;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_out;

  synchronous_ram_init_seq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (we),
    .i_addr      (addr),
    .i_data      (data_in),
    .o_mem_we    (w_mem_we),
    .o_mem_addr  (w_mem_addr),
    .o_mem_data  (w_mem_data),
    .o_run       (w_run),
    .o_init_done (init_done)
  );

  // Array has no reset; deterministic contents come from the clear sequencer.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else if (!w_run) begin
      r_data_out <= '0;
    end else if (we) begin
      r_data_out <= data_in;
    end else begin
      r_data_out <= r_mem[addr];
    end
  end

  assign data_out = r_data_out;

`ifdef SYNCHRONOUS_RAM_PARITY_EN
  localparam int NBYTES = DATA_W / 8;

  logic [NBYTES-1:0] r_par [DEPTH];
  logic [NBYTES-1:0] w_par_in;
  logic [NBYTES-1:0] w_par_rd;
  logic [DATA_W-1:0] w_rd_word;
  logic              r_parity_err;

  assign w_rd_word = r_mem[addr];

  always_comb begin
    w_par_in = '0;
    w_par_rd = '0;
    for (int i = 0; i < NBYTES; i++) begin
      w_par_in[i] = byte_parity(w_mem_data[i*8 +: 8]);
      w_par_rd[i] = byte_parity(w_rd_word[i*8 +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_par[w_mem_addr] <= w_par_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (w_run && !we) begin
      r_parity_err <= |(w_par_rd ^ r_par[addr]);
    end else begin
      r_parity_err <= 1'b0;
    end
  end

  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_synchronous_ram.sv
module tb_synchronous_ram;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        init_done;
`ifdef SYNCHRONOUS_RAM_PARITY_EN
  logic        parity_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [256];

  typedef struct {
    string       name;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  synchronous_ram dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
`ifdef SYNCHRONOUS_RAM_PARITY_EN
    .parity_err (parity_err),
`endif
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One user cycle: present inputs, let the edge happen, sample 1 time unit later.
  task automatic apply(input logic w, input logic [7:0] a, input logic [31:0] d);
    we = w; addr = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Expected read data from the storage model: write-first on writes.
  function automatic logic [31:0] model_access(input logic w, input logic [7:0] a, input logic [31:0] d);
    if (w) begin
      model[a] = d;
      return d;
    end
    return model[a];
  endfunction

  // Counts edges from reset release until init_done, checking data_out stays 0.
  task automatic wait_clear(input string name);
    int edges;
    int nz;
    edges = 0;
    nz = 0;
    while (1) begin
      @(posedge clk);
      #1;
      edges++;
      if (data_out !== 32'h0) nz++;
      if (init_done === 1'b1 || edges >= 1000) break;
    end
    check({name, "_clear_edges"}, 32'(edges), 32'd256);
    check({name, "_dout_zero_during_clear"}, 32'(nz), 32'd0);
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
  endtask

  initial begin
    logic [31:0] exp;
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;

    vecs[0] = '{"wr10",   1'b1, 8'd10, 32'h12345678, 32'h12345678};
    vecs[1] = '{"rd10",   1'b0, 8'd10, 32'h0,        32'h12345678};
    vecs[2] = '{"wr20",   1'b1, 8'd20, 32'hAABBCCDD, 32'hAABBCCDD};
    vecs[3] = '{"rd20",   1'b0, 8'd20, 32'h0,        32'hAABBCCDD};
    vecs[4] = '{"rd10b",  1'b0, 8'd10, 32'h0,        32'h12345678};
    vecs[5] = '{"rd30",   1'b0, 8'd30, 32'h0,        32'h00000000};

    rst_n = 1'b0; we = 1'b0; addr = 8'h0; data_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", data_out, 32'h0);
    check("reset_init_done", {31'h0, init_done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_init_done", {31'h0, init_done}, 32'h0);
    wait_clear("first");

    for (int i = 0; i < 6; i++) begin
      apply(vecs[i].we, vecs[i].addr, vecs[i].data);
      check(vecs[i].name, data_out, vecs[i].exp);
      exp = model_access(vecs[i].we, vecs[i].addr, vecs[i].data);
    end

    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      d = $urandom;
      exp = model_access(w, a, d);
      apply(w, a, d);
      check(w ? "rand_write" : "rand_read", data_out, exp);
`ifdef SYNCHRONOUS_RAM_PARITY_EN
      check("rand_parity", {31'h0, parity_err}, 32'h0);
`endif
    end

    // Mid-operation async reset, then user writes attempted during the clear.
    apply(1'b1, 8'd10, 32'hCAFEF00D);
    check("pre_reset_write", data_out, 32'hCAFEF00D);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_dout", data_out, 32'h0);
    check("async_reset_init_done", {31'h0, init_done}, 32'h0);
    we = 1'b1; addr = 8'd5; data_in = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("second");
    apply(1'b0, 8'd5, 32'h0);
    check("rd5_after_init_write", data_out, 32'h0);
    apply(1'b0, 8'd10, 32'h0);
    check("rd10_after_reset", data_out, 32'h0);
    apply(1'b0, 8'd20, 32'h0);
    check("rd20_after_reset", data_out, 32'h0);

`ifdef SYNCHRONOUS_RAM_PARITY_EN
    apply(1'b1, 8'd10, 32'h12345678);
    check("par_write_flag", {31'h0, parity_err}, 32'h0);
    apply(1'b0, 8'd10, 32'h0);
    check("par_clean_read", {31'h0, parity_err}, 32'h0);
    dut.r_mem[10][3] = ~dut.r_mem[10][3];
    apply(1'b0, 8'd10, 32'h0);
    check("par_corrupt_read", {31'h0, parity_err}, 32'h1);
    apply(1'b0, 8'd20, 32'h0);
    check("par_next_clean", {31'h0, parity_err}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
